// File: rtl/pdp8_pkg.sv
// Shared PDP-8 types: memory arbiter state, request source
// encoding and starvation counter width.
package pdp8_pkg;

  localparam int ARB_STARVE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  typedef enum logic [1:0] {
    SRC_IFU,
    SRC_EXEC_RD,
    SRC_EXEC_WR
  } arb_src_e;

  localparam logic [ARB_STARVE_W-1:0] ARB_STARVE_MAX = '1;

endpackage

// File: rtl/pdp_arb_pick.sv
// Combinational memory-port winner select.
// Ports: i_ifu_req, i_exec_rd_req, i_exec_wr_req, i_starve in; o_grant one-hot out.
module pdp_arb_pick
  import pdp8_pkg::*;
(
  input  logic       i_ifu_req,
  input  logic       i_exec_rd_req,
  input  logic       i_exec_wr_req,
  input  logic       i_starve,
  output logic [2:0] o_grant
);

  always_comb begin
    o_grant = '0;
    // A starved IFU overrides the normal EXEC-first order.
    if (i_ifu_req && i_starve)
      o_grant[SRC_IFU] = 1'b1;
    else if (i_exec_wr_req)
      o_grant[SRC_EXEC_WR] = 1'b1;
    else if (i_exec_rd_req)
      o_grant[SRC_EXEC_RD] = 1'b1;
    else if (i_ifu_req)
      o_grant[SRC_IFU] = 1'b1;
  end

endmodule

// File: rtl/pdp_mem_arbiter.sv
// Shares one PDP-8 memory port between IFD read, EXEC read, EXEC write.
// Ports: ifu_rd_*, exec_rd_*, exec_wr_* requester side; mem_* memory side.
module pdp_mem_arbiter
  import pdp8_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 12,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifu_rd_req,
  input  logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  output logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  ifu_rd_valid,
  input  logic                  exec_rd_req,
  input  logic [ADDR_WIDTH-1:0] exec_rd_addr,
  output logic [DATA_WIDTH-1:0] exec_rd_data,
  output logic                  exec_rd_valid,
  input  logic                  exec_wr_req,
  input  logic [ADDR_WIDTH-1:0] exec_wr_addr,
  input  logic [DATA_WIDTH-1:0] exec_wr_data,
  output logic                  exec_wr_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // WAIT spans MEM_LATENCY cycles, so the counter starts one short.
  localparam logic [2:0] LAT_LOAD =
    3'(MEM_LATENCY - 1);
  localparam logic [ARB_STARVE_W-1:0] STARVE_THR =
    ARB_STARVE_W'(STARVE_LIMIT);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  arb_src_e   r_src;
  arb_src_e   w_src;

  logic [ARB_STARVE_W-1:0] r_starve;
  logic [2:0]              r_lat;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_ifu_data;
  logic [DATA_WIDTH-1:0]   r_exec_data;

  logic       w_any_req;
  logic       w_starve;
  logic       w_is_wr;
  logic [2:0] w_grant;

  assign w_any_req = ifu_rd_req
                   | exec_rd_req
                   | exec_wr_req;
  assign w_starve  = r_starve >= STARVE_THR;
  assign w_is_wr   = r_src == SRC_EXEC_WR;

  pdp_arb_pick u_pick (
    .i_ifu_req     (ifu_rd_req),
    .i_exec_rd_req (exec_rd_req),
    .i_exec_wr_req (exec_wr_req),
    .i_starve      (w_starve),
    .o_grant       (w_grant)
  );

  always_comb begin
    w_src = SRC_IFU;
    unique case (1'b1)
      w_grant[SRC_EXEC_WR]: w_src = SRC_EXEC_WR;
      w_grant[SRC_EXEC_RD]: w_src = SRC_EXEC_RD;
      default:              w_src = SRC_IFU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    exec_wr_done  = 1'b0;
    ifu_rd_valid  = 1'b0;
    exec_rd_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_req      = 1'b1;
        mem_we       = w_is_wr;
        exec_wr_done = w_is_wr;
        w_state_nxt  = w_is_wr ? IDLE : WAIT;
      end
      WAIT: begin
        if (r_lat == '0) w_state_nxt = RESP;
      end
      RESP: begin
        ifu_rd_valid  = r_src == SRC_IFU;
        exec_rd_valid = r_src == SRC_EXEC_RD;
        w_state_nxt   = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_src       <= SRC_IFU;
      r_starve    <= '0;
      r_lat       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_ifu_data  <= '0;
      r_exec_data <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_src <= w_src;
            unique case (1'b1)
              w_grant[SRC_EXEC_WR]: begin
                r_addr  <= exec_wr_addr;
                r_wdata <= exec_wr_data;
              end
              w_grant[SRC_EXEC_RD]:
                r_addr <= exec_rd_addr;
              default:
                r_addr <= ifu_rd_addr;
            endcase
          end
          // Count EXEC wins only while IFU is actually waiting.
          if (!ifu_rd_req || w_grant[SRC_IFU])
            r_starve <= '0;
          else if (r_starve != ARB_STARVE_MAX)
            r_starve <= r_starve + 1'b1;
        end
        ISSUE: r_lat <= LAT_LOAD;
        WAIT: begin
          if (r_lat == '0) begin
            if (r_src == SRC_IFU)
              r_ifu_data <= mem_rdata;
            else
              r_exec_data <= mem_rdata;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr     = r_addr;
  assign mem_wdata    = r_wdata;
  assign ifu_rd_data  = r_ifu_data;
  assign exec_rd_data = r_exec_data;

endmodule

// File: tb/tb_pdp_mem_arbiter.sv
// Scoreboard bench for pdp_mem_arbiter with a latency-modelled memory.
// Reference model predicts grants/data; monitor compares DUT pulses.
module tb_pdp_mem_arbiter;
  import pdp8_pkg::*;

  localparam int LAT = 1;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_rd_req = 1'b0;
  logic [11:0] ifu_rd_addr = '0;
  logic [11:0] ifu_rd_data;
  logic        ifu_rd_valid;
  logic        exec_rd_req = 1'b0;
  logic [11:0] exec_rd_addr = '0;
  logic [11:0] exec_rd_data;
  logic        exec_rd_valid;
  logic        exec_wr_req = 1'b0;
  logic [11:0] exec_wr_addr = '0;
  logic [11:0] exec_wr_data = '0;
  logic        exec_wr_done;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata = '0;

  pdp_mem_arbiter #(
    .ADDR_WIDTH   (12),
    .DATA_WIDTH   (12),
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (SL)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ifu_rd_req    (ifu_rd_req),
    .ifu_rd_addr   (ifu_rd_addr),
    .ifu_rd_data   (ifu_rd_data),
    .ifu_rd_valid  (ifu_rd_valid),
    .exec_rd_req   (exec_rd_req),
    .exec_rd_addr  (exec_rd_addr),
    .exec_rd_data  (exec_rd_data),
    .exec_rd_valid (exec_rd_valid),
    .exec_wr_req   (exec_wr_req),
    .exec_wr_addr  (exec_wr_addr),
    .exec_wr_data  (exec_wr_data),
    .exec_wr_done  (exec_wr_done),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [11:0] data;
    int          at;
  } txn_t;

  txn_t resp_q[$];
  txn_t iss_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int free_at = 0;
  int starve = 0;
  logic [11:0] h_ifu = '0;
  logic [11:0] h_erd = '0;
  logic [11:0] mm  [4096];
  logic [11:0] mem [4096];

  bit ifu_pend = 0;
  bit erd_pend = 0;
  bit ewr_pend = 0;
  bit rnd_mode = 0;
  bit erd_auto = 0;

  task automatic chk(string n, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h",
               n, act, exp);
    end
  endtask

  // Memory model: sees the strobe mid-cycle, returns
  // read data LAT cycles after the strobe cycle.
  logic        s_req = 1'b0;
  logic        s_we = 1'b0;
  logic [11:0] s_addr = '0;
  logic [11:0] s_wd = '0;
  bit          pv [LAT];
  logic [11:0] pd [LAT];

  initial begin
    forever begin
      @(negedge clk);
      s_req  = mem_req;
      s_we   = mem_we;
      s_addr = mem_addr;
      s_wd   = mem_wdata;
    end
  end

  initial begin
    for (int i = 0; i < LAT; i++) pv[i] = 0;
    forever begin
      @(posedge clk);
      if (s_req && s_we) mem[s_addr] = s_wd;
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pd[i] = pd[i-1];
      end
      pv[0] = s_req && !s_we;
      pd[0] = mem[s_addr];
      mem_rdata <= pv[LAT-1] ? pd[LAT-1]
                             : 12'($urandom);
    end
  end

  // Reference model: one transaction at a time; a read
  // occupies the port for LAT+3 cycles, a write for 2.
  initial begin
    int   w;
    txn_t t;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        resp_q.delete();
        iss_q.delete();
        free_at = cyc + 1;
        starve = 0;
        h_ifu = '0;
        h_erd = '0;
      end else if (cyc >= free_at) begin
        if (ifu_rd_req && starve >= SL) w = 0;
        else if (exec_wr_req) w = 2;
        else if (exec_rd_req) w = 1;
        else if (ifu_rd_req) w = 0;
        else w = -1;
        if (!ifu_rd_req || w == 0) starve = 0;
        else if (starve < 15) starve++;
        if (w >= 0) begin
          t.kind = w;
          t.addr = (w == 0) ? ifu_rd_addr :
                   (w == 1) ? exec_rd_addr :
                              exec_wr_addr;
          if (w == 2) begin
            t.data = exec_wr_data;
            mm[t.addr] = t.data;
          end else begin
            t.data = mm[t.addr];
          end
          t.at = cyc;
          iss_q.push_back(t);
          t.at = (w == 2) ? cyc : cyc + LAT + 1;
          resp_q.push_back(t);
          free_at = (w == 2) ? cyc + 2
                             : cyc + LAT + 3;
        end
      end
    end
  end

  task automatic got_resp(int kind, logic [11:0] d);
    txn_t e;
    if (resp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL resp_unexp: src %0d pulsed, want none",
               kind);
    end else begin
      e = resp_q.pop_front();
      chk("resp_src", kind, e.kind);
      chk("resp_cycle", cyc, e.at);
      if (kind != 2) chk("resp_data", d, e.data);
      if (e.kind == 0) h_ifu = e.data;
      if (e.kind == 1) h_erd = e.data;
    end
  endtask

  // Monitor
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (!mem_req) begin
          chk("we_no_req", mem_we, 0);
        end else if (iss_q.size() == 0) begin
          chk("issue_unexp", mem_req, 0);
        end else begin
          e = iss_q.pop_front();
          chk("iss_we", mem_we, e.kind == 2);
          chk("iss_addr", mem_addr, e.addr);
          if (e.kind == 2)
            chk("iss_wdata", mem_wdata, e.data);
          chk("iss_cycle", cyc, e.at);
        end
        if (ifu_rd_valid)  got_resp(0, ifu_rd_data);
        if (exec_rd_valid) got_resp(1, exec_rd_data);
        if (exec_wr_done)  got_resp(2, '0);
        chk("ifu_hold", ifu_rd_data, h_ifu);
        chk("exec_hold", exec_rd_data, h_erd);
      end
    end
  end

  function automatic logic [11:0] raddr();
    if ($urandom_range(0, 7) == 0) return 12'o7777;
    return 12'($urandom);
  endfunction

  task automatic raise_ifu(logic [11:0] a);
    ifu_rd_addr = a; ifu_rd_req = 1; ifu_pend = 1;
  endtask

  task automatic raise_erd(logic [11:0] a);
    exec_rd_addr = a; exec_rd_req = 1; erd_pend = 1;
  endtask

  task automatic raise_ewr(logic [11:0] a,
                           logic [11:0] d);
    exec_wr_addr = a; exec_wr_data = d;
    exec_wr_req = 1; ewr_pend = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ifu_rd_valid) begin
      ifu_rd_req = 0; ifu_pend = 0;
    end
    if (exec_rd_valid) begin
      exec_rd_req = 0; erd_pend = 0;
    end
    if (exec_wr_done) begin
      exec_wr_req = 0; ewr_pend = 0;
    end
    if (rnd_mode) begin
      if (!ifu_pend && $urandom_range(0, 2) == 0)
        raise_ifu(raddr());
      if (!erd_pend && $urandom_range(0, 2) == 0)
        raise_erd(raddr());
      if (!ewr_pend && $urandom_range(0, 3) == 0)
        raise_ewr(raddr(), 12'($urandom));
    end
    if (erd_auto && !erd_pend)
      raise_erd(raddr());
  endtask

  task automatic drop_all();
    ifu_rd_req = 0; exec_rd_req = 0; exec_wr_req = 0;
    ifu_pend = 0; erd_pend = 0; ewr_pend = 0;
  endtask

  task automatic wait_done(int max);
    int n = 0;
    while ((ifu_pend || erd_pend || ewr_pend)
           && n < max) begin
      step();
      n++;
    end
    if (ifu_pend || erd_pend || ewr_pend) begin
      checks++;
      failures++;
      $display("FAIL timeout: pending %0b%0b%0b, want 000",
               ifu_pend, erd_pend, ewr_pend);
      drop_all();
    end
  endtask

  task automatic do_reset(int n);
    @(posedge clk);
    #1;
    reset = 1;
    drop_all();
    repeat (n) @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    chk("rst_ctl",
        {mem_req, mem_we, ifu_rd_valid,
         exec_rd_valid, exec_wr_done}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", {ifu_rd_data, exec_rd_data}, 0);
  endtask

  task automatic wait_issue(int max);
    int n = 0;
    while (!mem_req && n < max) begin
      step();
      n++;
    end
    chk("issue_seen", mem_req, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] v;
    for (int i = 0; i < 4096; i++) begin
      v = 12'($urandom);
      mm[i] = v;
      mem[i] = v;
    end
    mm[12'o0200] = 12'o7402;
    mem[12'o0200] = 12'o7402;

    do_reset(2);

    raise_ifu(12'o0200);
    wait_done(20);
    chk("t1_ifu_data", ifu_rd_data, 12'o7402);

    raise_ewr(12'o0300, 12'o1234);
    raise_ifu(12'o0200);
    wait_done(30);
    raise_erd(12'o0300);
    wait_done(20);
    chk("t2_rd_back", exec_rd_data, 12'o1234);

    raise_ifu(raddr());
    erd_auto = 1;
    repeat (40) step();
    erd_auto = 0;
    wait_done(40);

    raise_erd(12'o0055);
    wait_issue(10);
    do_reset(1);
    raise_erd(12'o0300);
    wait_done(20);
    chk("t4_after_rst", exec_rd_data, 12'o1234);

    raise_ifu(12'o7777);
    wait_issue(10);
    ifu_rd_req = 0;
    wait_done(20);

    v = 12'($urandom);
    raise_erd(12'o0400);
    raise_ewr(12'o0400, v);
    wait_done(30);
    chk("t6_rd_after_wr", exec_rd_data, v);

    rnd_mode = 1;
    repeat (300) step();
    rnd_mode = 0;
    wait_done(100);
    do_reset(1);
    rnd_mode = 1;
    repeat (300) step();
    rnd_mode = 0;
    wait_done(100);

    repeat (5) step();
    chk("resp_q_left", resp_q.size(), 0);
    chk("iss_q_left", iss_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
